// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the MIPS data-memory interface.
// Accepts one request at a time, checks it, and then either reads the memory,
// writes it, or performs read-modify-write for sub-word stores. It returns a
// one-cycle response that carries the load data or an error flag.
module load_store_unit #(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    MEMORY_DEPTH = 512,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h1001_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [3:0]            req_op,
   input  logic [DATA_WIDTH-1:0] req_address,
   input  logic [DATA_WIDTH-1:0] req_write_data,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  resp_error,
   output logic [DATA_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   output logic                  mem_write,
   output logic                  mem_read,
   input  logic [DATA_WIDTH-1:0] mem_read_data
);

   // First byte address past the end of the attached memory (exclusive bound).
   localparam logic [DATA_WIDTH-1:0] LIMIT_ADDRESS = BASE_ADDRESS + DATA_WIDTH'(4 * MEMORY_DEPTH);

   typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

   state_t                  state, next_state;
   logic [2:0]              op_q;          // signedness in [2], size in [1:0]
   logic [1:0]              offset_q;      // byte lane inside the word
   logic [DATA_WIDTH-1:0]   store_data_q;
   logic                    accept;
   logic                    illegal_op, misaligned, out_of_range, req_error;
   logic [4:0]              lane_shift;
   logic [15:0]             lane_data;
   logic                    lane_sign;
   logic [DATA_WIDTH-1:0]   load_value;
   logic [DATA_WIDTH-1:0]   lane_mask;
   logic [DATA_WIDTH-1:0]   merged_word;

   assign req_ready  = (state == IDLE) && !reset;
   assign accept     = req_valid && req_ready;
   assign mem_read   = !reset && ((state == RD) || (state == RMW_RD));
   assign mem_write  = !reset && (state == WR);
   assign resp_valid = !reset && (state == RESP);

   // Request checks, evaluated on the incoming request at acceptance.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      illegal_op = 1'b0;
      if (req_op[3]) begin
         illegal_op = (req_op[2:0] > 3'b010);
      end else begin
         illegal_op = (req_op[2:0] == 3'b011) || (req_op[2:0] == 3'b110) ||
                      (req_op[2:0] == 3'b111);
      end
      misaligned   = ((req_op[1:0] == 2'b01) && req_address[0]) ||
                     ((req_op[1:0] == 2'b10) && (req_address[1:0] != 2'b00));
      out_of_range = (req_address < BASE_ADDRESS) || (req_address >= LIMIT_ADDRESS);
      req_error    = illegal_op || misaligned || out_of_range;
   end

   // Lane extraction with sign/zero extension, and the sub-word merge for sb/sh.
   always_comb begin
      lane_shift = {offset_q, 3'b000};
      lane_data  = 16'(mem_read_data >> lane_shift);
      load_value = mem_read_data;
      lane_sign  = 1'b0;
      case (op_q[1:0])
         2'b00: begin
            lane_sign  = !op_q[2] && lane_data[7];
            load_value = {{(DATA_WIDTH-8){lane_sign}}, lane_data[7:0]};
         end
         2'b01: begin
            lane_sign  = !op_q[2] && lane_data[15];
            load_value = {{(DATA_WIDTH-16){lane_sign}}, lane_data};
         end
         default: load_value = mem_read_data;
      endcase
      lane_mask   = ((op_q[1:0] == 2'b00) ? DATA_WIDTH'(8'hFF) : DATA_WIDTH'(16'hFFFF)) << lane_shift;
      merged_word = (mem_read_data & ~lane_mask) | ((store_data_q << lane_shift) & lane_mask);
   end

   // Next-state logic for the request sequencer.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_error)                  next_state = RESP;
               else if (!req_op[3])            next_state = RD;
               else if (req_op[1:0] == 2'b10)  next_state = WR;
               else                            next_state = RMW_RD;
            end
         end
         RD:      next_state = RESP;
         RMW_RD:  next_state = WR;
         WR:      next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is written with non-blocking assignments only.
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Request capture, memory-side address/data registers and response payload.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q           <= '0;
         offset_q       <= '0;
         store_data_q   <= '0;
         mem_address    <= '0;
         mem_write_data <= '0;
         resp_data      <= '0;
         resp_error     <= 1'b0;
      end else begin
         if (accept) begin
            op_q         <= req_op[2:0];
            offset_q     <= req_address[1:0];
            store_data_q <= req_write_data;
            resp_data    <= '0;
            resp_error   <= req_error;
            // Memory-side registers move only when the memory is really accessed.
            if (!req_error) begin
               mem_address <= {req_address[DATA_WIDTH-1:2], 2'b00};
               if (req_op == 4'b1010) mem_write_data <= req_write_data;
            end
         end
         if (state == RD)     resp_data      <= load_value;
         if (state == RMW_RD) mem_write_data <= merged_word;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// requests, checked against a byte-addressed reference model of the memory.
module tb_load_store_unit;

   localparam logic [31:0] BASE  = 32'h1001_0000;
   localparam int          DEPTH = 512;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = '0;
   logic [31:0] req_address = '0;
   logic [31:0] req_write_data = '0;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_error;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_read_data;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
      logic [7:0]  lat;
      logic [7:0]  writes;
      logic [7:0]  reads;
      logic [31:0] wword;
      logic [31:0] waddr;
   } resp_t;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] data;
      logic [7:0]  lat;
      logic [31:0] wword;
   } dir_t;

   load_store_unit #(.DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .BASE_ADDRESS(BASE)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_address(req_address), .req_write_data(req_write_data),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   // Attached data memory: combinational read, write committed on posedge.
   logic [31:0] mem_words [DEPTH];
   logic [31:0] word_off;
   always_comb begin
      word_off      = mem_address - BASE;
      mem_read_data = (word_off < 32'd2048) ? mem_words[word_off[10:2]] : 32'h0;
   end
   always @(posedge clk) begin
      if (mem_write && (word_off < 32'd2048)) mem_words[word_off[10:2]] <= mem_write_data;
   end

   // Reference model: memory image as little-endian bytes.
   logic [7:0] ref_bytes [4*DEPTH];

   function automatic resp_t ref_exec(input logic [3:0] op, input logic [31:0] addr,
                                      input logic [31:0] wdata);
      resp_t  e;
      int     size;
      bit     sgn, illegal;
      longint a;
      int     idx, base_idx;
      logic [31:0] v;
      e = '0;
      sgn = 1'b0;
      case (op[2:0])
         3'b000:  begin size = 1; sgn = 1'b1; end
         3'b001:  begin size = 2; sgn = 1'b1; end
         3'b010:  size = 4;
         3'b100:  size = 1;
         3'b101:  size = 2;
         default: size = 0;
      endcase
      illegal = (size == 0) || (op[3] && op[2]);
      a = {32'd0, addr};
      e.err = illegal || (a < longint'(BASE)) || (a >= longint'(BASE) + 2048) ||
              ((size != 0) && ((a % size) != 0));
      if (e.err) begin
         e.lat = 8'd1;
         return e;
      end
      idx = int'(a - longint'(BASE));
      if (op[3]) begin
         for (int i = 0; i < size; i++) ref_bytes[idx + i] = wdata[8*i +: 8];
         base_idx = idx - (idx % 4);
         for (int i = 0; i < 4; i++) e.wword[8*i +: 8] = ref_bytes[base_idx + i];
         e.waddr  = addr & ~32'h3;
         e.writes = 8'd1;
         e.reads  = (size < 4) ? 8'd1 : 8'd0;
         e.lat    = (size < 4) ? 8'd3 : 8'd2;
      end else begin
         v = '0;
         for (int i = 0; i < size; i++) v[8*i +: 8] = ref_bytes[idx + i];
         if (sgn && (size < 4) && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
         e.data  = v;
         e.reads = 8'd1;
         e.lat   = 8'd2;
      end
      return e;
   endfunction

   // Issue one request from IDLE and observe it until its response (bounded).
   task automatic do_req(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, output resp_t o);
      o = '0;
      @(negedge clk);
      req_op = op; req_address = addr; req_write_data = wdata; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (k > 1) @(negedge clk);
         if (mem_write) begin
            o.writes = o.writes + 8'd1;
            o.wword  = mem_write_data;
            o.waddr  = mem_address;
         end
         if (mem_read) o.reads = o.reads + 8'd1;
         if (resp_valid) begin
            o.lat  = 8'(k);
            o.data = resp_data;
            o.err  = resp_error;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_hold: ready=%b resp_valid=%b rd=%b wr=%b, expected all 0",
                  req_ready, resp_valid, mem_read, mem_write);
      end
      reset = 1'b0;
      #1;
      tests_run++;
      if (resp_data !== 32'h0 || resp_error !== 1'b0 || mem_address !== 32'h0 ||
          mem_write_data !== 32'h0 || req_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_values: data=%h err=%b addr=%h wdata=%h ready=%b, expected 0/0/0/0/1",
                  resp_data, resp_error, mem_address, mem_write_data, req_ready);
      end
   endtask

   task automatic test_word_and_subword();
      dir_t  tbl [8];
      resp_t o, e;
      tbl[0] = '{4'b1010, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0000_0000, 8'd2, 32'hDEAD_BEEF};
      tbl[1] = '{4'b0010, 32'h1001_0004, 32'h0,         32'hDEAD_BEEF, 8'd2, 32'h0};
      tbl[2] = '{4'b0000, 32'h1001_0007, 32'h0,         32'hFFFF_FFDE, 8'd2, 32'h0};
      tbl[3] = '{4'b0100, 32'h1001_0007, 32'h0,         32'h0000_00DE, 8'd2, 32'h0};
      tbl[4] = '{4'b0001, 32'h1001_0004, 32'h0,         32'hFFFF_BEEF, 8'd2, 32'h0};
      tbl[5] = '{4'b0101, 32'h1001_0004, 32'h0,         32'h0000_BEEF, 8'd2, 32'h0};
      tbl[6] = '{4'b1000, 32'h1001_0005, 32'h0000_0012, 32'h0000_0000, 8'd3, 32'hDEAD_12EF};
      tbl[7] = '{4'b0010, 32'h1001_0004, 32'h0,         32'hDEAD_12EF, 8'd2, 32'h0};
      for (int i = 0; i < 8; i++) begin
         e = ref_exec(tbl[i].op, tbl[i].addr, tbl[i].wdata);
         do_req(tbl[i].op, tbl[i].addr, tbl[i].wdata, o);
         tests_run++;
         if (o.data !== tbl[i].data || o.err !== 1'b0 || o.lat !== tbl[i].lat ||
             o.writes !== e.writes || o.reads !== e.reads) begin
            tests_failed++;
            $display("FAIL directed[%0d]: got data=%h err=%b lat=%0d wr=%0d rd=%0d, expected data=%h err=0 lat=%0d wr=%0d rd=%0d",
                     i, o.data, o.err, o.lat, o.writes, o.reads, tbl[i].data, tbl[i].lat, e.writes, e.reads);
         end
         if (tbl[i].op[3]) begin
            tests_run++;
            if (o.wword !== tbl[i].wword || o.waddr !== 32'h1001_0004) begin
               tests_failed++;
               $display("FAIL directed_write[%0d]: got word=%h addr=%h, expected word=%h addr=10010004",
                        i, o.wword, o.waddr, tbl[i].wword);
            end
         end
      end
   endtask

   task automatic test_errors();
      logic [3:0]  ops   [10] = '{4'b0010, 4'b1001, 4'b1010, 4'b1010, 4'b1100,
                                  4'b0011, 4'b0110, 4'b0111, 4'b1011, 4'b0101};
      logic [31:0] addrs [10] = '{32'h1001_0002, 32'h1001_0001, 32'h1000_FFFC, 32'h1001_0800,
                                  32'h1001_0004, 32'h1001_0004, 32'h1001_0004, 32'h1001_0004,
                                  32'h1001_0004, 32'h1001_0003};
      resp_t o;
      for (int i = 0; i < 10; i++) begin
         do_req(ops[i], addrs[i], 32'h5555_AAAA, o);
         tests_run++;
         if (o.err !== 1'b1 || o.lat !== 8'd1 || o.data !== 32'h0 ||
             o.writes !== 8'd0 || o.reads !== 8'd0) begin
            tests_failed++;
            $display("FAIL error[%0d] op=%b addr=%h: got err=%b lat=%0d data=%h wr=%0d rd=%0d, expected err=1 lat=1 data=0 wr=0 rd=0",
                     i, ops[i], addrs[i], o.err, o.lat, o.data, o.writes, o.reads);
         end
      end
   endtask

   task automatic test_boundaries();
      logic [3:0]  ops   [8] = '{4'b0010, 4'b1010, 4'b0010, 4'b0100, 4'b0000,
                                 4'b0100, 4'b0000, 4'b0010};
      logic [31:0] addrs [8] = '{BASE + 32'h7FC, BASE + 32'h7FC, BASE + 32'h7FC, BASE,
                                 BASE + 32'h7FF, BASE + 32'h800, BASE - 32'h1, 32'hFFFF_FFFC};
      resp_t o, e;
      for (int i = 0; i < 8; i++) begin
         e = ref_exec(ops[i], addrs[i], 32'hC001_D00D);
         do_req(ops[i], addrs[i], 32'hC001_D00D, o);
         tests_run++;
         if (o.data !== e.data || o.err !== e.err || o.lat !== e.lat ||
             o.writes !== e.writes || o.reads !== e.reads) begin
            tests_failed++;
            $display("FAIL boundary[%0d] addr=%h: got data=%h err=%b lat=%0d, expected data=%h err=%b lat=%0d",
                     i, addrs[i], o.data, o.err, o.lat, e.data, e.err, e.lat);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] legal [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                4'b0101, 4'b1000, 4'b1001, 4'b1010};
      logic [3:0]  op;
      logic [31:0] addr, wdata;
      int          choice;
      resp_t       o, e;
      for (int n = 0; n < 120; n++) begin
         op     = ($urandom_range(0, 9) == 0) ? 4'($urandom) : legal[$urandom_range(0, 7)];
         choice = $urandom_range(0, 19);
         if (choice == 0)      addr = $urandom;
         else if (choice == 1) addr = BASE + 32'h7F8 + 32'($urandom_range(0, 15));
         else                  addr = BASE + 32'($urandom_range(0, 255));
         if (choice >= 4) begin
            if (op[1:0] == 2'b01) addr[0]   = 1'b0;
            if (op[1:0] == 2'b10) addr[1:0] = 2'b00;
         end
         wdata = $urandom;
         e = ref_exec(op, addr, wdata);
         do_req(op, addr, wdata, o);
         tests_run++;
         if (o.data !== e.data || o.err !== e.err || o.lat !== e.lat || o.writes !== e.writes ||
             o.reads !== e.reads || (e.writes != 0 && (o.wword !== e.wword || o.waddr !== e.waddr))) begin
            tests_failed++;
            $display("FAIL random[%0d] op=%b addr=%h: got data=%h err=%b lat=%0d wr=%0d rd=%0d word=%h, expected data=%h err=%b lat=%0d wr=%0d rd=%0d word=%h",
                     n, op, addr, o.data, o.err, o.lat, o.writes, o.reads, o.wword,
                     e.data, e.err, e.lat, e.writes, e.reads, e.wword);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] addr = BASE + 32'h40;
      logic [31:0] wdata = $urandom;
      logic [8:0]  ready_tr = '0, resp_tr = '0, wr_tr = '0, rd_tr = '0;
      logic [31:0] second_data = '0;
      resp_t       e1, e2;
      e1 = ref_exec(4'b1010, addr, wdata);
      e2 = ref_exec(4'b0010, addr, 32'h0);
      @(negedge clk);
      req_op = 4'b1010; req_address = addr; req_write_data = wdata; req_valid = 1'b1;
      ready_tr[0] = req_ready;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin req_op = 4'b0010; req_write_data = 32'h0; end
         if (k == 4) req_valid = 1'b0;
         ready_tr[k] = req_ready;
         resp_tr[k]  = resp_valid;
         wr_tr[k]    = mem_write;
         rd_tr[k]    = mem_read;
         if (k == 5) second_data = resp_data;
      end
      tests_run++;
      if (ready_tr !== 9'h1C9 || resp_tr !== 9'h024 || wr_tr !== 9'h002 || rd_tr !== 9'h010) begin
         tests_failed++;
         $display("FAIL back_to_back_timing: ready=%b resp=%b wr=%b rd=%b, expected ready=111001001 resp=000100100 wr=000000010 rd=000010000",
                  ready_tr, resp_tr, wr_tr, rd_tr);
      end
      tests_run++;
      if (second_data !== e2.data || e1.err !== 1'b0) begin
         tests_failed++;
         $display("FAIL back_to_back_data: got %h, expected %h", second_data, e2.data);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] addr = BASE + 32'h102;
      logic        wr_before, wr_during, ready_during, resp_during;
      logic [3:0]  resp_after = '0;
      logic        ready_after;
      resp_t       o, e;
      @(negedge clk);
      req_op = 4'b1001; req_address = addr; req_write_data = 32'h0000_A5A5; req_valid = 1'b1;
      @(negedge clk);                      // RMW_RD
      req_valid = 1'b0;
      @(negedge clk);                      // WR
      wr_before = mem_write;
      reset = 1'b1;
      #1;
      wr_during = mem_write; ready_during = req_ready; resp_during = resp_valid;
      @(negedge clk);
      reset = 1'b0;
      #1;
      ready_after = req_ready;
      for (int k = 0; k < 4; k++) begin
         resp_after[k] = resp_valid;
         @(negedge clk);
      end
      tests_run++;
      if (wr_before !== 1'b1 || wr_during !== 1'b0 || ready_during !== 1'b0 || resp_during !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_op_gate: wr_before=%b wr_during=%b ready=%b resp=%b, expected 1/0/0/0",
                  wr_before, wr_during, ready_during, resp_during);
      end
      tests_run++;
      if (ready_after !== 1'b1 || resp_after !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_mid_op_idle: ready=%b resp=%b, expected ready=1 resp=0000", ready_after, resp_after);
      end
      e = ref_exec(4'b0010, addr & ~32'h3, 32'h0);
      do_req(4'b0010, addr & ~32'h3, 32'h0, o);
      tests_run++;
      if (o.data !== e.data || o.err !== 1'b0 || o.lat !== 8'd2) begin
         tests_failed++;
         $display("FAIL reset_mid_op_word: got %h err=%b lat=%0d, expected %h err=0 lat=2",
                  o.data, o.err, o.lat, e.data);
      end
   endtask

   task automatic test_memory_image();
      int          bad = 0;
      logic [31:0] w;
      for (int i = 0; i < DEPTH; i++) begin
         for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_bytes[4*i + b];
         if (mem_words[i] !== w) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL memory_image: %0d words differ, expected 0", bad);
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_words[i] = $urandom;
         for (int b = 0; b < 4; b++) ref_bytes[4*i + b] = mem_words[i][8*b +: 8];
      end
      test_reset();
      test_word_and_subword();
      test_errors();
      test_boundaries();
      test_back_to_back();
      test_random();
      test_reset_mid_op();
      test_memory_image();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
